// File: rtl/pulse_meter_pkg.sv
// Shared definitions for the pulse period meter: FSM encodings and counter limit helper.
package pulse_meter_pkg;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StWaitRise = 2'd1,
        StMeasHigh = 2'd2,
        StMeasLow  = 2'd3
    } state_e;

    // All-ones value of a counter of the given width.
    function automatic longint unsigned cnt_max(input int unsigned width);
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/sig_sync_edge.sv
// Synchronises a slow asynchronous input into clk_i and flags its rising and falling edges.
module sig_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic sig_i,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;
    logic                   level;

    assign level = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], sig_i};
        hist_d = level;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign rise_o = level & ~hist_q;
    assign fall_o = ~level & hist_q;

endmodule

// File: rtl/pulse_period_meter.sv
// Measures high time and rise-to-rise period of a slow signal in clk_i cycles,
// single-shot or continuous, with abort and saturation timeout.
module pulse_period_meter
    import pulse_meter_pkg::*;
#(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             sig_i,
    input  logic             start_i,
    input  logic             cont_i,
    input  logic             abort_i,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] high_o,
    output logic             valid_o,
    output logic             busy_o,
    output logic             timeout_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] high_r_q, high_r_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;
    logic             busy_q, busy_d;
    logic             rise, fall;
    logic             cnt_sat;

    sig_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i  (clk_i),
        .rst_n_i(rst_n_i),
        .sig_i  (sig_i),
        .rise_o (rise),
        .fall_o (fall)
    );

    assign cnt_sat = (cnt_q == CNT_MAX);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // A fall at saturation would need a period beyond CNT_MAX, so it times out instead.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) state_d = StWaitRise;
            end
            StWaitRise: begin
                if (abort_i)      state_d = StIdle;
                else if (rise)    state_d = StMeasHigh;
                else if (cnt_sat) state_d = StIdle;
            end
            StMeasHigh: begin
                if (abort_i)      state_d = StIdle;
                else if (cnt_sat) state_d = StIdle;
                else if (fall)    state_d = StMeasLow;
            end
            StMeasLow: begin
                if (abort_i)      state_d = StIdle;
                else if (rise)    state_d = cont_i ? StMeasHigh : StIdle;
                else if (cnt_sat) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d     = cnt_q;
        high_r_d  = high_r_q;
        period_d  = period_q;
        high_d    = high_q;
        valid_d   = 1'b0;
        timeout_d = 1'b0;
        busy_d    = (state_q != StIdle);
        unique case (state_q)
            StIdle: begin
                if (start_i) cnt_d = '0;
            end
            StWaitRise: begin
                if (!abort_i) begin
                    if (rise)         cnt_d = CNT_ONE;
                    else if (cnt_sat) timeout_d = 1'b1;
                    else              cnt_d = cnt_q + CNT_ONE;
                end
            end
            StMeasHigh: begin
                if (!abort_i) begin
                    if (cnt_sat) begin
                        timeout_d = 1'b1;
                    end else if (fall) begin
                        high_r_d = cnt_q;
                        cnt_d    = cnt_q + CNT_ONE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            StMeasLow: begin
                if (!abort_i) begin
                    if (rise) begin
                        period_d = cnt_q;
                        high_d   = high_r_q;
                        valid_d  = 1'b1;
                        cnt_d    = CNT_ONE;
                    end else if (cnt_sat) begin
                        timeout_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q     <= '0;
            high_r_q  <= '0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            high_r_q  <= high_r_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            busy_q    <= busy_d;
        end
    end

    assign period_o  = period_q;
    assign high_o    = high_q;
    assign valid_o   = valid_q;
    assign busy_o    = busy_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_pulse_period_meter.sv
// Self-checking bench for pulse_period_meter: table vectors, random waveforms, corner sequences.
module tb_pulse_period_meter;

    typedef struct {
        int h;
        int l;
        int n;
        bit c;
        int drop;
        int exp_cnt;
        int exp_high;
        int exp_per;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        sig = 1'b0, start = 1'b0, cont = 1'b0, abort = 1'b0;
    logic [15:0] period, high;
    logic        valid, busy, tmo;

    logic        sig2 = 1'b0, start2 = 1'b0;
    logic [3:0]  period2, high2;
    logic        valid2, busy2, tmo2;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int tmo_cnt = 0;
    int v2_cnt = 0;
    int last_per = 0;
    int last_high = 0;

    int q_per[$], q_high[$], q_t[$], q_bat[$], q_baf[$];
    int hs[$], ls[$];
    logic pend = 1'b0;

    vec_t vecs[6];

    pulse_period_meter #(.CNT_W(16), .SYNC_STAGES(2)) u_dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .sig_i    (sig),
        .start_i  (start),
        .cont_i   (cont),
        .abort_i  (abort),
        .period_o (period),
        .high_o   (high),
        .valid_o  (valid),
        .busy_o   (busy),
        .timeout_o(tmo)
    );

    pulse_period_meter #(.CNT_W(4), .SYNC_STAGES(2)) u_dut4 (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .sig_i    (sig2),
        .start_i  (start2),
        .cont_i   (1'b0),
        .abort_i  (1'b0),
        .period_o (period2),
        .high_o   (high2),
        .valid_o  (valid2),
        .busy_o   (busy2),
        .timeout_o(tmo2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pend) q_baf.push_back(int'(busy));
        pend <= valid;
        if (valid) begin
            q_per.push_back(int'(period));
            q_high.push_back(int'(high));
            q_t.push_back(cyc);
            q_bat.push_back(int'(busy));
        end
        if (tmo) tmo_cnt <= tmo_cnt + 1;
        if (valid2) v2_cnt <= v2_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_q();
        q_per.delete();
        q_high.delete();
        q_t.delete();
        q_bat.delete();
        q_baf.delete();
    endtask

    // Drives hs/ls phases after a start pulse and checks every result against
    // the phase lengths: high = h, period = h + l, valid spacing = next period.
    task automatic run_seq(input bit c, input int drop, input int exp_cnt);
        int n;
        n = hs.size();
        clear_q();
        tick();
        start = 1'b1;
        cont  = c;
        tick();
        start = 1'b0;
        tick();
        tick();
        for (int k = 0; k < n; k++) begin
            if (drop != 0 && k == drop) cont = 1'b0;
            sig = 1'b1;
            repeat (hs[k]) tick();
            sig = 1'b0;
            repeat (ls[k]) tick();
        end
        if (drop == n) cont = 1'b0;
        sig = 1'b1;
        repeat (6) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        sig   = 1'b0;
        cont  = 1'b0;
        repeat (6) tick();
        chk("valid_count", q_per.size(), exp_cnt);
        for (int j = 0; j < q_per.size() && j < exp_cnt; j++) begin
            bit cont_on;
            chk($sformatf("high[%0d]", j), q_high[j], hs[j]);
            chk($sformatf("period[%0d]", j), q_per[j], hs[j] + ls[j]);
            chk($sformatf("busy_at_valid[%0d]", j), q_bat[j], 1);
            cont_on = c && (drop == 0 || j + 1 < drop);
            if (j < q_baf.size())
                chk($sformatf("busy_after_valid[%0d]", j), q_baf[j], cont_on ? 1 : 0);
            if (j > 0) chk($sformatf("spacing[%0d]", j), q_t[j] - q_t[j-1], hs[j] + ls[j]);
        end
        if (exp_cnt > 0) begin
            last_high = hs[exp_cnt-1];
            last_per  = hs[exp_cnt-1] + ls[exp_cnt-1];
        end
        chk("busy_end", int'(busy), 0);
    endtask

    initial begin
        vecs[0] = '{h:1, l:1, n:3, c:1'b0, drop:0, exp_cnt:1, exp_high:1, exp_per:2};
        vecs[1] = '{h:1, l:2, n:6, c:1'b1, drop:4, exp_cnt:4, exp_high:1, exp_per:3};
        vecs[2] = '{h:4, l:4, n:5, c:1'b1, drop:0, exp_cnt:5, exp_high:4, exp_per:8};
        vecs[3] = '{h:2, l:2, n:4, c:1'b1, drop:0, exp_cnt:4, exp_high:2, exp_per:4};
        vecs[4] = '{h:3, l:5, n:3, c:1'b0, drop:0, exp_cnt:1, exp_high:3, exp_per:8};
        vecs[5] = '{h:7, l:1, n:3, c:1'b1, drop:0, exp_cnt:3, exp_high:7, exp_per:8};

        #2 rst_n = 1'b0;
        #1;
        chk("rst_period", int'(period), 0);
        chk("rst_high", int'(high), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_timeout", int'(tmo), 0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (4) tick();

        foreach (vecs[i]) begin
            hs.delete();
            ls.delete();
            for (int k = 0; k < vecs[i].n; k++) begin
                hs.push_back(vecs[i].h);
                ls.push_back(vecs[i].l);
            end
            run_seq(vecs[i].c, vecs[i].drop, vecs[i].exp_cnt);
            if (q_per.size() > 0) begin
                chk($sformatf("vec%0d_high", i), q_high[0], vecs[i].exp_high);
                chk($sformatf("vec%0d_period", i), q_per[0], vecs[i].exp_per);
            end
        end

        for (int r = 0; r < 6; r++) begin
            int n, drop;
            n = $urandom_range(6, 2);
            hs.delete();
            ls.delete();
            for (int k = 0; k < n; k++) begin
                hs.push_back($urandom_range(12, 1));
                ls.push_back($urandom_range(12, 1));
            end
            drop = (r == 5) ? $urandom_range(n, 1) : 0;
            run_seq(1'b1, drop, (drop != 0) ? drop : n);
        end

        // Abort while measuring the low phase.
        clear_q();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        sig = 1'b1;
        repeat (2) tick();
        sig = 1'b0;
        repeat (5) tick();
        chk("abort_busy_before", int'(busy), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        chk("abort_busy_after", int'(busy), 0);
        sig = 1'b1;
        repeat (6) tick();
        sig = 1'b0;
        repeat (4) tick();
        chk("abort_no_valid", q_per.size(), 0);
        chk("abort_period_held", int'(period), last_per);
        chk("abort_high_held", int'(high), last_high);
        hs = '{3};
        ls = '{4};
        run_seq(1'b0, 0, 1);

        // Asynchronous reset while measuring the high phase.
        tick();
        start = 1'b1;
        cont  = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        sig = 1'b1;
        repeat (5) tick();
        chk("pre_rst_busy", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_period", int'(period), 0);
        chk("mid_rst_high", int'(high), 0);
        chk("mid_rst_valid", int'(valid), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_timeout", int'(tmo), 0);
        tick();
        sig  = 1'b0;
        cont = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        hs = '{5, 2};
        ls = '{3, 6};
        run_seq(1'b1, 0, 2);

        // Narrow counter: measure once, then saturate with sig_i held low.
        tick();
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        tick();
        tick();
        sig2 = 1'b1;
        repeat (2) tick();
        sig2 = 1'b0;
        repeat (3) tick();
        sig2 = 1'b1;
        repeat (6) tick();
        sig2 = 1'b0;
        repeat (6) tick();
        chk("w4_valid_count", v2_cnt, 1);
        chk("w4_period", int'(period2), 5);
        chk("w4_high", int'(high2), 2);
        tick();
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        begin
            int t_cnt, t_at;
            t_cnt = 0;
            t_at  = -1;
            for (int j = 1; j <= 22; j++) begin
                @(negedge clk);
                if (tmo2) begin
                    t_cnt++;
                    if (t_at < 0) t_at = j;
                end
            end
            chk("w4_timeout_pulses", t_cnt, 1);
            chk("w4_timeout_cycle", t_at, 17);
        end
        chk("w4_period_held", int'(period2), 5);
        chk("w4_high_held", int'(high2), 2);
        chk("w4_no_new_valid", v2_cnt, 1);
        chk("w4_busy_end", int'(busy2), 0);
        chk("main_no_timeout", tmo_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
